// File: rtl/nbhd_pkg.sv
// Shared constants and helpers for the 3x3 neighbourhood window former.
package nbhd_pkg;

    localparam int DATA_W  = 8;
    localparam int WIN_DIM = 3;
    localparam int COORD_W = 9;

    typedef logic [COORD_W-1:0] coord_t;

    // Flat window element index: r=0 is the oldest row, c=0 the oldest column.
    function automatic int win_idx(input int r, input int c);
        return WIN_DIM * r + c;
    endfunction

endpackage

// File: rtl/nbhd_line_ram.sv
// Single-row line RAM: synchronous write, combinational read, so the old
// contents of an address are visible in the same cycle they are overwritten.
module nbhd_line_ram #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/nbhd_window_former.sv
// Streaming 3x3 valid-mode window former: two line RAMs hold the previous rows,
// three column shift registers form the window presented to the kernel stage.
module nbhd_window_former #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = nbhd_pkg::DATA_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sof,
    input  logic [DATA_W-1:0]              pixelIn,
    input  logic                           pixelValid,
    output logic [9*DATA_W-1:0]            windowOut,
    output logic                           windowValid,
    output logic [nbhd_pkg::COORD_W-1:0]   centerRow,
    output logic [nbhd_pkg::COORD_W-1:0]   centerCol,
    output logic                           frameDone
);

    import nbhd_pkg::*;

    localparam int     LINE_AW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam coord_t LAST_COL = coord_t'(IMG_WIDTH - 1);
    localparam coord_t LAST_ROW = coord_t'(IMG_HEIGHT - 1);
    localparam coord_t ONE      = coord_t'(1);
    localparam coord_t TWO      = coord_t'(2);

    coord_t            row;
    coord_t            col;
    coord_t            cur_row;
    coord_t            cur_col;
    logic              accept;
    logic [DATA_W-1:0] line_a_old;
    logic [DATA_W-1:0] line_b_old;
    logic [DATA_W-1:0] new_col [WIN_DIM];
    logic [DATA_W-1:0] win [WIN_DIM][WIN_DIM];

    assign accept = pixelValid && !reset;

    // sof forces the incoming pixel to (0,0) wherever the counters happen to be.
    assign cur_row = sof ? '0 : row;
    assign cur_col = sof ? '0 : col;

    nbhd_line_ram #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (DATA_W),
        .ADDR_W (LINE_AW)
    ) line_a (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_col[LINE_AW-1:0]),
        .wr_data (pixelIn),
        .rd_data (line_a_old)
    );

    nbhd_line_ram #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (DATA_W),
        .ADDR_W (LINE_AW)
    ) line_b (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_col[LINE_AW-1:0]),
        .wr_data (line_a_old),
        .rd_data (line_b_old)
    );

    assign new_col[0] = line_b_old;
    assign new_col[1] = line_a_old;
    assign new_col[2] = pixelIn;

    for (genvar r = 0; r < WIN_DIM; r++) begin : g_row
        for (genvar c = 0; c < WIN_DIM; c++) begin : g_col
            assign windowOut[DATA_W*win_idx(r, c) +: DATA_W] = win[r][c];
        end
    end

    // Shift registers are not cleared at row wrap; stale columns only appear
    // while col < 2, where no window is flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            row         <= '0;
            col         <= '0;
            windowValid <= 1'b0;
            frameDone   <= 1'b0;
            centerRow   <= '0;
            centerCol   <= '0;
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            windowValid <= 1'b0;
            frameDone   <= 1'b0;
            if (pixelValid) begin
                for (int r = 0; r < WIN_DIM; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                    win[r][2] <= new_col[r];
                end
                if (cur_row >= TWO && cur_col >= TWO) begin
                    windowValid <= 1'b1;
                    centerRow   <= cur_row - ONE;
                    centerCol   <= cur_col - ONE;
                end
                if (cur_col == LAST_COL) begin
                    col <= '0;
                    if (cur_row == LAST_ROW) begin
                        row       <= '0;
                        frameDone <= 1'b1;
                    end else begin
                        row <= cur_row + ONE;
                    end
                end else begin
                    col <= cur_col + ONE;
                    row <= cur_row;
                end
            end
        end
    end

endmodule

// File: tb/tb_nbhd_window_former.sv
// Self-checking bench: a small 4x4 instance for directed/random scenarios and a
// 512-wide instance for column wrap and back-to-back frames, both against an image model.
module tb_nbhd_window_former;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int AH = 4;
    localparam int BW = 512;
    localparam int BH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_sof, a_valid;
    logic [7:0]  a_pix;
    logic [71:0] a_win;
    logic        a_wv, a_done;
    logic [8:0]  a_cr, a_cc;

    logic        b_reset, b_sof, b_valid;
    logic [7:0]  b_pix;
    logic [71:0] b_win;
    logic        b_wv, b_done;
    logic [8:0]  b_cr, b_cc;

    nbhd_window_former #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .DATA_W(DW)) dut_a (
        .clk         (clk),
        .reset       (a_reset),
        .sof         (a_sof),
        .pixelIn     (a_pix),
        .pixelValid  (a_valid),
        .windowOut   (a_win),
        .windowValid (a_wv),
        .centerRow   (a_cr),
        .centerCol   (a_cc),
        .frameDone   (a_done)
    );

    nbhd_window_former #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .DATA_W(DW)) dut_b (
        .clk         (clk),
        .reset       (b_reset),
        .sof         (b_sof),
        .pixelIn     (b_pix),
        .pixelValid  (b_valid),
        .windowOut   (b_win),
        .windowValid (b_wv),
        .centerRow   (b_cr),
        .centerCol   (b_cc),
        .frameDone   (b_done)
    );

    int checks = 0;
    int errors = 0;

    int         m_row [2];
    int         m_col [2];
    logic [7:0] img [2][4][512];
    int         win_count [2];
    int         done_count [2];

    logic [71:0] exp_win;
    logic        exp_wv, exp_done;
    logic [8:0]  exp_cr, exp_cc;

    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // Drives one cycle on the selected instance, advances the image model and compares.
    task automatic applyStimulus(input int sel, input logic rst, input logic s,
                                 input logic v, input logic [7:0] p);
        int w, h, r, c;
        logic [71:0] o_win;
        logic        o_wv, o_done;
        logic [8:0]  o_cr, o_cc;
        w = (sel == 0) ? AW : BW;
        h = (sel == 0) ? AH : BH;
        if (sel == 0) begin
            a_reset = rst; a_sof = s; a_valid = v; a_pix = p;
        end else begin
            b_reset = rst; b_sof = s; b_valid = v; b_pix = p;
        end
        @(posedge clk);
        #1;
        exp_wv   = 1'b0;
        exp_done = 1'b0;
        if (rst) begin
            m_row[sel] = 0;
            m_col[sel] = 0;
            exp_win    = '0;
            exp_cr     = '0;
            exp_cc     = '0;
        end else if (v) begin
            if (s) begin
                m_row[sel] = 0;
                m_col[sel] = 0;
            end
            r = m_row[sel];
            c = m_col[sel];
            img[sel][r][c] = p;
            if (r >= 2 && c >= 2) begin
                exp_wv = 1'b1;
                exp_cr = 9'(r - 1);
                exp_cc = 9'(c - 1);
                for (int k = 0; k < 9; k++) begin
                    exp_win[8*k +: 8] = img[sel][r - 2 + k / 3][c - 2 + k % 3];
                end
            end
            if (c == w - 1) begin
                m_col[sel] = 0;
                exp_done   = (r == h - 1);
                m_row[sel] = (r == h - 1) ? 0 : r + 1;
            end else begin
                m_col[sel] = c + 1;
            end
        end
        o_win  = (sel == 0) ? a_win  : b_win;
        o_wv   = (sel == 0) ? a_wv   : b_wv;
        o_done = (sel == 0) ? a_done : b_done;
        o_cr   = (sel == 0) ? a_cr   : b_cr;
        o_cc   = (sel == 0) ? a_cc   : b_cc;
        checkOutput("windowValid", {71'd0, o_wv}, {71'd0, exp_wv});
        checkOutput("frameDone", {71'd0, o_done}, {71'd0, exp_done});
        if (exp_wv || rst) begin
            checkOutput("windowOut", o_win, exp_win);
            checkOutput("centerRow", {63'd0, o_cr}, {63'd0, exp_cr});
            checkOutput("centerCol", {63'd0, o_cc}, {63'd0, exp_cc});
        end
        if (o_wv) win_count[sel]++;
        if (o_done) done_count[sel]++;
    endtask

    task automatic clearCounts(input int sel);
        win_count[sel]  = 0;
        done_count[sel] = 0;
    endtask

    initial begin
        a_reset = 1'b1; a_sof = 1'b0; a_valid = 1'b0; a_pix = '0;
        b_reset = 1'b1; b_sof = 1'b0; b_valid = 1'b0; b_pix = '0;
        m_row = '{0, 0};
        m_col = '{0, 0};
        clearCounts(0);
        clearCounts(1);

        $display("[TB] reset");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'h5a);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h00);

        $display("[TB] full frame, continuous valid");
        clearCounts(0);
        for (int r = 0; r < AH; r++) begin
            for (int c = 0; c < AW; c++) begin
                applyStimulus(0, 1'b0, (r == 0 && c == 0), 1'b1, 8'(16 * r + c));
                if (r == 2 && c == 2) checkOutput("firstWindow", a_win, 72'h22_21_20_12_11_10_02_01_00);
                if (r == 3 && c == 3) checkOutput("lastCentre", {54'd0, a_cr, a_cc}, {54'd0, 9'd2, 9'd2});
            end
        end
        checkOutput("s1WindowCount", 72'(win_count[0]), 72'd4);
        checkOutput("s1DoneCount", 72'(done_count[0]), 72'd1);

        $display("[TB] full frame, valid toggling");
        clearCounts(0);
        for (int r = 0; r < AH; r++) begin
            for (int c = 0; c < AW; c++) begin
                applyStimulus(0, 1'b0, (r == 0 && c == 0), 1'b1, 8'(16 * r + c));
                applyStimulus(0, 1'b0, 1'($urandom), 1'b0, 8'($urandom));
            end
        end
        checkOutput("s2WindowCount", 72'(win_count[0]), 72'd4);
        checkOutput("s2DoneCount", 72'(done_count[0]), 72'd1);

        $display("[TB] sof restart mid-frame");
        clearCounts(0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b0, (i == 0), 1'b1, 8'(16 * (i / 4) + i % 4));
        end
        for (int r = 0; r < AH; r++) begin
            for (int c = 0; c < AW; c++) begin
                applyStimulus(0, 1'b0, (r == 0 && c == 0), 1'b1, 8'(8'h80 + 16 * r + c));
                if (r == 2 && c == 2) checkOutput("restartWindow", a_win, 72'hA2_A1_A0_92_91_90_82_81_80);
            end
        end
        checkOutput("s3WindowCount", 72'(win_count[0]), 72'd4);
        checkOutput("s3DoneCount", 72'(done_count[0]), 72'd1);

        $display("[TB] reset mid-frame");
        clearCounts(0);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(0, 1'b0, (i == 0), 1'b1, 8'(16 * (i / 4) + i % 4));
        end
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'h77);
        checkOutput("resetWindowOut", a_win, 72'd0);
        for (int r = 0; r < AH; r++) begin
            for (int c = 0; c < AW; c++) begin
                applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'(8'h40 + 16 * r + c));
            end
        end
        checkOutput("s4WindowCount", 72'(win_count[0]), 72'd5);
        checkOutput("s4DoneCount", 72'(done_count[0]), 72'd1);

        $display("[TB] random stream");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(0, ($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 3) != 0), 8'($urandom));
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] wide image, two back-to-back frames");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h00);
        clearCounts(1);
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < BH; r++) begin
                for (int c = 0; c < BW; c++) begin
                    if ($urandom_range(0, 3) == 0) applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'($urandom));
                    applyStimulus(1, 1'b0, (r == 0 && c == 0), 1'b1, 8'($urandom));
                    if (f == 0 && r == 2 && c == BW - 1) checkOutput("wideLastCol", 72'(b_cc), 72'd510);
                    if (f == 1 && r == 2 && c == 2) checkOutput("frame2FirstCentre", {54'd0, b_cr, b_cc}, {54'd0, 9'd1, 9'd1});
                end
            end
        end
        checkOutput("wideWindowCount", 72'(win_count[1]), 72'(2 * (BH - 2) * (BW - 2)));
        checkOutput("wideDoneCount", 72'(done_count[1]), 72'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
